// File: rtl/addkey_arbiter.sv
// Round-robin arbiter sharing one addkey unit between two requesters.
// Both sides use the 4-phase start/finish handshake.
module addkey_arbiter #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_start,
    input  logic [WIDTH-1:0] req0_in,
    input  logic [WIDTH-1:0] req0_key,
    output logic             req0_finish,
    output logic [WIDTH-1:0] req0_out,
    input  logic             req1_start,
    input  logic [WIDTH-1:0] req1_in,
    input  logic [WIDTH-1:0] req1_key,
    output logic             req1_finish,
    output logic [WIDTH-1:0] req1_out,
    output logic             ak_start,
    output logic [WIDTH-1:0] ak_in,
    output logic [WIDTH-1:0] ak_key,
    input  logic             ak_finish,
    input  logic [WIDTH-1:0] ak_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_gnt, w_gnt_nxt;
    logic             r_rr, w_rr_nxt;
    logic             r_ak_start, w_ak_start_nxt;
    logic [WIDTH-1:0] r_ak_in, w_ak_in_nxt;
    logic [WIDTH-1:0] r_ak_key, w_ak_key_nxt;
    logic [1:0]       r_fin, w_fin_nxt;
    logic [WIDTH-1:0] r_out0, w_out0_nxt;
    logic [WIDTH-1:0] r_out1, w_out1_nxt;
    logic             w_gstart;
    logic             w_pick;

    assign w_gstart = r_gnt ? req1_start : req0_start;
    // Contention goes to the rr pointer; a lone request wins outright.
    assign w_pick   = (req0_start & req1_start) ? r_rr : req1_start;

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_rr_nxt       = r_rr;
        w_ak_start_nxt = r_ak_start;
        w_ak_in_nxt    = r_ak_in;
        w_ak_key_nxt   = r_ak_key;
        w_fin_nxt      = r_fin;
        w_out0_nxt     = r_out0;
        w_out1_nxt     = r_out1;
        unique case (r_state)
            S_IDLE: begin
                if (req0_start | req1_start) begin
                    w_gnt_nxt      = w_pick;
                    w_ak_in_nxt    = w_pick ? req1_in : req0_in;
                    w_ak_key_nxt   = w_pick ? req1_key : req0_key;
                    w_ak_start_nxt = 1'b1;
                    w_state_nxt    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (ak_finish) begin
                    w_ak_start_nxt = 1'b0;
                    if (w_gstart) begin
                        if (r_gnt) w_out1_nxt = ak_result;
                        else       w_out0_nxt = ak_result;
                        w_fin_nxt[r_gnt] = 1'b1;
                        w_state_nxt      = S_DONE;
                    end else begin
                        w_state_nxt = S_RELEASE;
                    end
                end
            end
            S_DONE: begin
                if (!w_gstart) begin
                    w_fin_nxt[r_gnt] = 1'b0;
                    w_rr_nxt         = ~r_gnt;
                    w_state_nxt      = ak_finish ? S_RELEASE : S_IDLE;
                end
            end
            S_RELEASE: begin
                if (!ak_finish) begin
                    w_rr_nxt    = ~r_gnt;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= 1'b0;
            r_rr       <= 1'b0;
            r_ak_start <= 1'b0;
            r_ak_in    <= '0;
            r_ak_key   <= '0;
            r_fin      <= '0;
            r_out0     <= '0;
            r_out1     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rr       <= w_rr_nxt;
            r_ak_start <= w_ak_start_nxt;
            r_ak_in    <= w_ak_in_nxt;
            r_ak_key   <= w_ak_key_nxt;
            r_fin      <= w_fin_nxt;
            r_out0     <= w_out0_nxt;
            r_out1     <= w_out1_nxt;
        end
    end

    assign ak_start    = r_ak_start;
    assign ak_in       = r_ak_in;
    assign ak_key      = r_ak_key;
    assign req0_finish = r_fin[0];
    assign req1_finish = r_fin[1];
    assign req0_out    = r_out0;
    assign req1_out    = r_out1;

endmodule

// File: tb/tb_addkey_arbiter.sv
// Directed bench for addkey_arbiter with a 2-cycle addkey model.
// Covers single, contended, fair, aborted and reset-interrupted requests.
module tb_addkey_arbiter;

    localparam int W = 128;
    localparam logic [W-1:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [W-1:0] IN_A = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [W-1:0] EX_A = 128'h40bfabf406ee4d3042ca6b997a5c5816;
    localparam logic [W-1:0] IN_B = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [W-1:0] EX_B = 128'h85539f4136ad7e3a35407a244c60c16d;
    localparam logic [W-1:0] IN_C = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [W-1:0] EX_C = 128'h1bb609508bf236b74e0cd49113c51dd3;
    localparam logic [W-1:0] IN_D = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [W-1:0] EX_D = 128'hdde13153f7e149b106dc54f3efa3782c;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_start = 1'b0, req1_start = 1'b0;
    logic [W-1:0] req0_in = '0, req0_key = '0;
    logic [W-1:0] req1_in = '0, req1_key = '0;
    logic         req0_finish, req1_finish;
    logic [W-1:0] req0_out, req1_out;
    logic         ak_start;
    logic [W-1:0] ak_in, ak_key;
    logic         ak_finish = 1'b0;
    logic [W-1:0] ak_result = '0;

    int n_cmp = 0;
    int n_err = 0;

    addkey_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_start(req0_start), .req0_in(req0_in), .req0_key(req0_key),
        .req0_finish(req0_finish), .req0_out(req0_out),
        .req1_start(req1_start), .req1_in(req1_in), .req1_key(req1_key),
        .req1_finish(req1_finish), .req1_out(req1_out),
        .ak_start(ak_start), .ak_in(ak_in), .ak_key(ak_key),
        .ak_finish(ak_finish), .ak_result(ak_result)
    );

    always #5 clk = ~clk;

    // addkey unit: result 2 cycles after start, held until start drops
    int ak_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            ak_cnt    <= 0;
            ak_finish <= 1'b0;
        end else if (ak_start && !ak_finish) begin
            if (ak_cnt == 1) begin
                ak_finish <= 1'b1;
                ak_result <= ak_in ^ ak_key;
                ak_cnt    <= 0;
            end else begin
                ak_cnt <= ak_cnt + 1;
            end
        end else if (!ak_start) begin
            ak_finish <= 1'b0;
            ak_cnt    <= 0;
        end
    end

    int   glog[$];
    logic prev_ak = 1'b0;
    int   lowcnt = 0;
    int   mingap = 99;
    logic seen1 = 1'b0;
    always @(negedge clk) begin
        if (ak_start && !prev_ak) begin
            glog.push_back((ak_in == req1_in) ? 1 : 0);
            if (lowcnt < mingap) mingap = lowcnt;
            lowcnt = 0;
        end
        if (!ak_start) lowcnt++;
        prev_ak = ak_start;
        if (req1_finish) seen1 = 1'b1;
    end

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic txn(input int id, input logic [W-1:0] din,
                       input logic [W-1:0] key,
                       output logic [W-1:0] res, output int lat);
        bit done = 0;
        @(posedge clk); #1;
        if (id == 0) begin
            req0_in = din; req0_key = key; req0_start = 1'b1;
        end else begin
            req1_in = din; req1_key = key; req1_start = 1'b1;
        end
        lat = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk); #1;
            lat++;
            done = (id == 0) ? req0_finish : req1_finish;
        end
        chk($sformatf("finish_timeout%0d", id), W'(done), W'(1));
        res = (id == 0) ? req0_out : req1_out;
        if (id == 0) req0_start = 1'b0;
        else         req1_start = 1'b0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            done = (id == 0) ? !req0_finish : !req1_finish;
        end
        chk($sformatf("finish_drop%0d", id), W'(done), W'(1));
    endtask

    task automatic wait_ak(output bit ok);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            ok = ak_start;
        end
    endtask

    logic [W-1:0] r0, r1;
    int           l0, l1;
    bit           ok;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ak_start", W'(ak_start), W'(0));
        chk("rst_ak_in", ak_in, '0);
        chk("rst_ak_key", ak_key, '0);
        chk("rst_fin0", W'(req0_finish), W'(0));
        chk("rst_fin1", W'(req1_finish), W'(0));
        chk("rst_out0", req0_out, '0);
        chk("rst_out1", req1_out, '0);
        rst = 1'b0;

        // single requester
        seen1 = 1'b0;
        txn(0, IN_A, KEY, r0, l0);
        chk("single_out0", r0, EX_A);
        chk("single_lat", W'(l0), W'(4));
        chk("single_fin1", W'(seen1), W'(0));

        // contention straight after reset
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        glog.delete();
        fork
            txn(0, IN_B, KEY, r0, l0);
            txn(1, IN_C, KEY, r1, l1);
        join
        chk("sim_ngrants", W'(glog.size()), W'(2));
        chk("sim_first", W'(glog.size() > 0 ? glog[0] : 9), W'(0));
        chk("sim_second", W'(glog.size() > 1 ? glog[1] : 9), W'(1));
        chk("sim_out0", r0, EX_B);
        chk("sim_out1", r1, EX_C);

        // fairness under continuous requests
        glog.delete();
        mingap = 99;
        fork
            for (int k = 0; k < 3; k++) txn(0, IN_A, KEY, r0, l0);
            for (int k = 0; k < 3; k++) txn(1, IN_C, KEY, r1, l1);
        join
        chk("fair_ngrants", W'(glog.size()), W'(6));
        for (int k = 0; k < 6; k++)
            chk($sformatf("fair_g%0d", k),
                W'(glog.size() > k ? glog[k] : 9), W'(k % 2));
        chk("fair_gap", W'(mingap >= 1), W'(1));
        chk("fair_out0", r0, EX_A);
        chk("fair_out1", r1, EX_C);

        // requester 1 result persists
        txn(1, IN_D, KEY, r1, l1);
        chk("r1_out", r1, EX_D);
        repeat (3) @(posedge clk);
        #1;
        chk("r1_hold", req1_out, EX_D);
        chk("r1_hold_fin", W'(req1_finish), W'(0));

        // abort by requester 1 while rr favours it
        txn(0, IN_A, KEY, r0, l0);
        seen1 = 1'b0;
        @(posedge clk); #1;
        req1_in = IN_C; req1_key = KEY; req1_start = 1'b1;
        wait_ak(ok);
        chk("abort_grant", W'(ok), W'(1));
        req1_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_fin1", W'(seen1), W'(0));
        chk("abort_out1", req1_out, EX_D);
        chk("abort_out0", req0_out, EX_A);
        chk("abort_idle", W'(ak_start), W'(0));
        glog.delete();
        fork
            txn(0, IN_B, KEY, r0, l0);
            txn(1, IN_D, KEY, r1, l1);
        join
        chk("abort_next", W'(glog.size() > 0 ? glog[0] : 9), W'(0));
        chk("abort_next_out0", r0, EX_B);

        // reset while BUSY with rr favouring requester 1
        txn(0, IN_A, KEY, r0, l0);
        @(posedge clk); #1;
        req0_in = IN_B; req0_key = KEY; req0_start = 1'b1;
        wait_ak(ok);
        chk("rb_grant", W'(ok), W'(1));
        rst = 1'b1;
        req0_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rb_ak_start", W'(ak_start), W'(0));
        chk("rb_fin0", W'(req0_finish), W'(0));
        chk("rb_fin1", W'(req1_finish), W'(0));
        glog.delete();
        fork
            txn(0, IN_A, KEY, r0, l0);
            txn(1, IN_B, KEY, r1, l1);
        join
        chk("rb_first", W'(glog.size() > 0 ? glog[0] : 9), W'(0));
        chk("rb_out0", r0, EX_A);
        chk("rb_out1", r1, EX_B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addkey_arbiter.md
Name: addkey_arbiter

Overview:
- Shares a single addkey datapath instance between two requesters, using round-robin arbitration.
- Each requester side uses the codebase's 4-phase start/finish handshake.
- The addkey side uses the same handshake.
- Sits between AES round sequencers (e.g. encrypt and decrypt lanes) and one addkey unit, so the 128-bit XOR datapath is instantiated once.

Parameters:
- WIDTH, 128, width of the data, key and result buses.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req0_start  input  1  requester 0 operation request; held high until req0_finish is seen.
- req0_in  input  WIDTH  requester 0 state; stable while req0_start is high.
- req0_key  input  WIDTH  requester 0 round key; stable while req0_start is high.
- req0_finish  output  1  requester 0 result valid.
- req0_out  output  WIDTH  requester 0 result, registered.
- req1_start, req1_in, req1_key, req1_finish, req1_out: same as requester 0, for requester 1.
- ak_start  output  1  start to the shared addkey unit.
- ak_in  output  WIDTH  registered state to addkey.
- ak_key  output  WIDTH  registered key to addkey.
- ak_finish  input  1  addkey completion.
- ak_result  input  WIDTH  addkey result, valid while ak_finish is high.

Behaviour:
- Reset (rst high at posedge):
  - state returns to IDLE.
  - ak_start=0, ak_in=0, ak_key=0.
  - req0_finish=0, req1_finish=0, req0_out=0, req1_out=0.
  - rr pointer=0 (requester 0 has priority).
  - Reset mid-transaction abandons the transaction; no finish is asserted afterwards.
- State IDLE:
  - If no req_start is high, remain in IDLE.
  - If only one req_start is high, grant it.
  - If both are high, grant the requester selected by the rr pointer.
  - On grant: register that requester's in/key into ak_in/ak_key, set ak_start=1, record grant id, go to BUSY.
  - ak_start rises on the first posedge at which req_start is sampled high.
- State BUSY:
  - ak_start stays 1 and ak_in/ak_key stay stable; the requester's inputs are not re-sampled.
  - When ak_finish=1 and the granted requester's start is still high:
    - capture ak_result into req<g>_out;
    - set req<g>_finish=1 and ak_start=0;
    - go to DONE.
  - When ak_finish=1 but the granted requester has dropped start (abort):
    - set ak_start=0;
    - discard the result; req<g>_out is unchanged and no finish is asserted;
    - go to RELEASE.
- State DONE:
  - Hold req<g>_finish=1 and req<g>_out.
  - When req<g>_start=0 is sampled, set req<g>_finish=0.
  - Go to IDLE once req<g>_start=0 and ak_finish=0 are both sampled; otherwise go to RELEASE.
- State RELEASE:
  - Wait for ak_finish=0, then go to IDLE.
- Round-robin:
  - On every exit from DONE or RELEASE, the rr pointer is set to the requester not just granted.
  - This applies to aborted transactions as well.
- Transaction end:
  - A new grant can only occur from IDLE, so the addkey unit always sees start low for at least one cycle between transactions.
- Latency: req start high to req finish high = 1 (grant) + addkey latency + 1 (capture) cycles.
- Result holding:
  - req<g>_out keeps its value after finish drops, until that requester's next completed transaction.
  - The other requester's output is never disturbed.
- The non-granted requester's finish stays 0 for the whole transaction; its request stays pending.
- A requester that re-raises start while its own finish is still high is not re-granted until the full IDLE return.
- Width: XOR is done in addkey; the arbiter is pure routing and registering, with no arithmetic.

Test Plan:
- Single requester: key=2b7e151628aed2a6abf7158809cf4f3c, req0_in=6bc1bee22e409f96e93d7e117393172a -> req0_finish rises, req0_out=40bfabf406ee4d3042ca6b997a5c5816, req1_finish stays 0.
- Simultaneous requests after reset: req0_in=ae2d8a571e03ac9c9eb76fac45af8e51, req1_in=30c81c46a35ce411e5fbc1191a0a52ef, same key:
  - requester 0 is served first, req0_out=85539f4136ad7e3a35407a244c60c16d;
  - then requester 1, req1_out=1bb609508bf236b74e0cd49113c51dd3.
- Fairness: both requesters re-request continuously for 6 transactions -> grants strictly alternate 0,1,0,1,0,1; ak_start is low for ≥1 cycle between each.
- Abort: req1 (in=f69f2445df4f9b17ad2b417be66c3710) drops start during BUSY -> req1_finish never rises, req1_out is unchanged, the next grant goes to req0.
- Requester 1 outputs: req1 completes with in=f69f2445df4f9b17ad2b417be66c3710 -> req1_out=dde13153f7e149b106dc54f3efa3782c, which persists after req1_finish falls.
- Reset during BUSY:
  - ak_start drops on the next cycle and all finishes are 0;
  - the rr pointer returns to 0;
  - a following req0 transaction completes with the correct result.
